rr_mux_pipe: RTL and testbench

- Parametrised N-input, registered multiplexer with per-channel valid/ready handshake and built-in arbitration (round-robin or fixed priority).
- Successor to the combinational 2:1 word mux: generalised in width and channel count, with a one-stage output register and backpressure.
- Used in the datapath wherever several producers share one consumer, e.g. writeback-source selection and memory-request merging between pipeline stages.

---
 rtl/rr_mux_pipe.sv | 106 ++++++++++
 tb/tb_rr_mux_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_pipe
// Brief    : N-input registered mux with valid/ready handshake and built-in
//            round-robin / fixed-priority arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     prio_mode,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*WIDTH-1:0]  in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    localparam logic [CH_W-1:0] c_last_ch = CH_W'(NUM_CH - 1);

    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_data;
    logic [CH_W-1:0]        r_out_ch;
    logic [CH_W-1:0]        r_rr_ptr;

    logic                   w_load_en;
    logic                   w_found;
    logic [CH_W-1:0]        w_grant_idx;
    int                     w_scan_idx;
    logic [WIDTH-1:0]       w_ch_data [NUM_CH];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_unpack
            assign w_ch_data[g] = in_data[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_load_en = !r_out_valid || out_ready;

    // Both scans run from lowest to highest priority so the last hit wins.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = 0;
        if (prio_mode) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    w_found     = 1'b1;
                    w_grant_idx = CH_W'(i);
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                w_scan_idx = int'(r_rr_ptr) + k;
                if (w_scan_idx >= NUM_CH) begin
                    w_scan_idx = w_scan_idx - NUM_CH;
                end
                if (in_valid[w_scan_idx]) begin
                    w_found     = 1'b1;
                    w_grant_idx = CH_W'(w_scan_idx);
                end
            end
        end
    end

    // Reset gating keeps producers from seeing a grant while the register is cleared.
    always_comb begin
        in_ready = '0;
        if (w_load_en && w_found && !Reset) begin
            in_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= c_last_ch;
        end else if (w_load_en) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ch_data[w_grant_idx];
                r_out_ch    <= w_grant_idx;
                if (!prio_mode) begin
                    r_rr_ptr <= w_grant_idx;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_pipe
// Brief    : Scoreboard bench for rr_mux_pipe with a reference arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_pipe;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                    Clk = 1'b0;
    logic                    Reset;
    logic                    prio_mode;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_ready;

    always #5 Clk = ~Clk;

    rr_mux_pipe #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .prio_mode (prio_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [CH_W+WIDTH-1:0] sb_q [$];
    logic                  m_ov;
    logic [CH_W-1:0]       m_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic set_ch(input int i, input logic [WIDTH-1:0] d);
        in_data[i*WIDTH +: WIDTH] = d;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        logic                  load;
        logic                  found;
        int                    gnt;
        logic [NUM_CH-1:0]     exp_rdy;
        logic [CH_W+WIDTH-1:0] item;
        #1;
        load  = !m_ov || out_ready;
        found = 1'b0;
        gnt   = 0;
        if (prio_mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && in_valid[i]) begin
                    found = 1'b1;
                    gnt   = i;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int idx;
                idx = (int'(m_ptr) + k) % NUM_CH;
                if (!found && in_valid[idx]) begin
                    found = 1'b1;
                    gnt   = idx;
                end
            end
        end
        exp_rdy = '0;
        if (load && found) exp_rdy[gnt] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (m_ov && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_depth", 64'(sb_q.size()), 64'd1);
            end else begin
                item = sb_q.pop_front();
                check("out_ch", 64'(out_ch), 64'(item[WIDTH +: CH_W]));
                check("out_data", 64'(out_data), 64'(item[WIDTH-1:0]));
            end
        end
        if (load) begin
            if (found) begin
                sb_q.push_back({CH_W'(gnt), in_data[gnt*WIDTH +: WIDTH]});
                m_ov = 1'b1;
                if (!prio_mode) m_ptr = CH_W'(gnt);
            end else begin
                m_ov = 1'b0;
            end
        end
        @(posedge Clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_ov));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset     = 1'b1;
        prio_mode = 1'b0;
        in_valid  = 4'b1111;
        in_data   = '0;
        out_ready = 1'b1;
        m_ov      = 1'b0;
        m_ptr     = CH_W'(NUM_CH - 1);
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_ch", 64'(out_ch), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge Clk);
        #1;
        in_valid = '0;
        Reset    = 1'b0;

        repeat (5) begin
            cycle();
            check("idle_data", 64'(out_data), 64'd0);
            check("idle_ch", 64'(out_ch), 64'd0);
        end

        // Round-robin over all channels
        prio_mode = 1'b0;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 32'hA0 + 32'(i));
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_seq", 64'(out_ch), 64'(k % NUM_CH));
        end

        // Fixed priority
        prio_mode = 1'b1;
        in_valid  = 4'b1010;
        repeat (4) begin
            cycle();
            check("fp_ch", 64'(out_ch), 64'd1);
        end
        in_valid = 4'b1000;
        cycle();
        check("fp_drop", 64'(out_ch), 64'd3);
        in_valid = '0;
        cycle();

        // Backpressure with a pending channel 0
        prio_mode = 1'b0;
        set_ch(2, 32'hDEADBEEF);
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        cycle();
        set_ch(0, 32'h55);
        in_valid = 4'b0001;
        repeat (4) begin
            cycle();
            check("bp_data", 64'(out_data), 64'hDEADBEEF);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_next_ch", 64'(out_ch), 64'd0);
        check("bp_next_data", 64'(out_data), 64'h55);

        // Wrap-around and sparse requests
        set_ch(3, 32'h33);
        in_valid = 4'b1000;
        cycle();
        check("wrap_pre", 64'(out_ch), 64'd3);
        set_ch(1, 32'h11);
        in_valid = 4'b1010;
        cycle();
        check("wrap_1", 64'(out_ch), 64'd1);
        cycle();
        check("wrap_3", 64'(out_ch), 64'd3);
        in_valid = 4'b0100;
        repeat (3) begin
            cycle();
            check("single_2", 64'(out_ch), 64'd2);
        end

        // Asynchronous reset between edges
        in_valid = 4'b1111;
        cycle();
        cycle();
        #2;
        Reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd0);
        check("arst_ch", 64'(out_ch), 64'd0);
        sb_q.delete();
        m_ov  = 1'b0;
        m_ptr = CH_W'(NUM_CH - 1);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cycle();
        check("arst_first", 64'(out_ch), 64'd0);

        in_valid = '0;
        repeat (2) cycle();
        check("sb_final", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
